// File: rtl/dwt_pass_sequencer.sv
// rtl/dwt_pass_sequencer.sv - issues row/column DWT engine passes level by level with halving regions
// Only one waiting request is kept; the newest level overwrites the one already latched.
module dwt_pass_sequencer #(
  parameter int         IMAGE_WIDTH  = 640,
  parameter int         IMAGE_HEIGHT = 480,
  parameter int         DIM_BITS     = 10,
  parameter logic [3:0] MAX_LEVEL    = 4'd10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          level,
  input  logic                level_update,
  input  logic                frame_start,
  output logic                engine_start,
  input  logic                engine_done,
  output logic                pass_dir,
  output logic [DIM_BITS-1:0] pass_width,
  output logic [DIM_BITS-1:0] pass_height,
  output logic [3:0]          pass_level,
  output logic                busy,
  output logic                seq_done,
  output logic [3:0]          levels_done
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [DIM_BITS-1:0] FULL_W  = DIM_BITS'(IMAGE_WIDTH);
  localparam logic [DIM_BITS-1:0] FULL_H  = DIM_BITS'(IMAGE_HEIGHT);
  localparam logic [DIM_BITS-1:0] MIN_DIM = DIM_BITS'(2);

  state_t              state, state_n;
  logic [3:0]          target, target_n;
  logic                pending, pending_n;
  logic [3:0]          pending_level, pending_level_n;
  logic                engine_start_n, pass_dir_n, busy_n, seq_done_n;
  logic [DIM_BITS-1:0] pass_width_n, pass_height_n;
  logic [3:0]          pass_level_n, levels_done_n;

  logic                request;
  logic [3:0]          req_level, req_target;
  logic [DIM_BITS-1:0] next_w, next_h;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      target        <= 4'd0;
      pending       <= 1'b0;
      pending_level <= 4'd0;
      engine_start  <= 1'b0;
      pass_dir      <= 1'b0;
      pass_width    <= '0;
      pass_height   <= '0;
      pass_level    <= 4'd0;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
      levels_done   <= 4'd0;
    end else begin
      state         <= state_n;
      target        <= target_n;
      pending       <= pending_n;
      pending_level <= pending_level_n;
      engine_start  <= engine_start_n;
      pass_dir      <= pass_dir_n;
      pass_width    <= pass_width_n;
      pass_height   <= pass_height_n;
      pass_level    <= pass_level_n;
      busy          <= busy_n;
      seq_done      <= seq_done_n;
      levels_done   <= levels_done_n;
    end
  end

  always_comb begin
    state_n         = state;
    target_n        = target;
    pending_n       = pending;
    pending_level_n = pending_level;
    engine_start_n  = 1'b0;
    pass_dir_n      = pass_dir;
    pass_width_n    = pass_width;
    pass_height_n   = pass_height;
    pass_level_n    = pass_level;
    seq_done_n      = 1'b0;
    levels_done_n   = levels_done;

    request    = level_update | frame_start;
    // A fresh request in IDLE is newer than anything latched while busy.
    req_level  = request ? level : pending_level;
    req_target = (req_level > MAX_LEVEL) ? MAX_LEVEL : req_level;
    // Dimensions of level pass_level+1.
    next_w     = FULL_W >> pass_level;
    next_h     = FULL_H >> pass_level;

    case (state)
      IDLE: begin
        if (request || pending) begin
          pending_n = 1'b0;
          target_n  = req_target;
          if (req_target == 4'd0) begin
            state_n       = DONE;
            seq_done_n    = 1'b1;
            levels_done_n = 4'd0;
          end else begin
            state_n        = WAIT;
            engine_start_n = 1'b1;
            pass_dir_n     = 1'b0;
            pass_level_n   = 4'd1;
            pass_width_n   = FULL_W;
            pass_height_n  = FULL_H;
          end
        end
      end
      WAIT: begin
        if (request) begin
          pending_n       = 1'b1;
          pending_level_n = level;
        end
        if (engine_done) begin
          if (!pass_dir) begin
            engine_start_n = 1'b1;
            pass_dir_n     = 1'b1;
          end else if (pass_level == target || next_w < MIN_DIM || next_h < MIN_DIM) begin
            state_n       = DONE;
            seq_done_n    = 1'b1;
            levels_done_n = pass_level;
          end else begin
            engine_start_n = 1'b1;
            pass_dir_n     = 1'b0;
            pass_level_n   = pass_level + 4'd1;
            pass_width_n   = next_w;
            pass_height_n  = next_h;
          end
        end
      end
      DONE: begin
        if (request) begin
          pending_n       = 1'b1;
          pending_level_n = level;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == WAIT);
  end

endmodule

// File: tb/tb_dwt_pass_sequencer.sv
// tb/tb_dwt_pass_sequencer.sv - self-checking bench for dwt_pass_sequencer
// Expected passes come from a per-level dimension model; engine responses are emulated.
module tb_dwt_pass_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] level = 4'd0;
  logic       level_update = 1'b0;
  logic       frame_start = 1'b0;
  logic       engine_done = 1'b0;
  logic       engine_start, pass_dir, busy, seq_done;
  logic [9:0] pass_width, pass_height;
  logic [3:0] pass_level, levels_done;

  int tests = 0;
  int errors = 0;

  dwt_pass_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .level        (level),
    .level_update (level_update),
    .frame_start  (frame_start),
    .engine_start (engine_start),
    .engine_done  (engine_done),
    .pass_dir     (pass_dir),
    .pass_width   (pass_width),
    .pass_height  (pass_height),
    .pass_level   (pass_level),
    .busy         (busy),
    .seq_done     (seq_done),
    .levels_done  (levels_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int dir;
    int w;
    int h;
    int lvl;
  } pass_t;

  typedef struct {
    int lv;
    bit fs;
    int lat;
    int exp_n;
    int exp_lv;
    int exp_w;
    int exp_h;
  } vec_t;

  pass_t model_q[$];

  function automatic void check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endfunction

  // Reference pass list: row then column per level, stopping when a level is too small.
  function automatic int build_model(input int lv);
    int t;
    int done;
    t = (lv > 10) ? 10 : lv;
    done = 0;
    model_q.delete();
    for (int k = 1; k <= t; k++) begin
      int w;
      int h;
      w = 640 >> (k - 1);
      h = 480 >> (k - 1);
      if (w < 2 || h < 2) break;
      model_q.push_back('{0, w, h, k});
      model_q.push_back('{1, w, h, k});
      done = k;
    end
    return done;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [3:0] lv, input bit fs);
    level = lv;
    if (fs) frame_start = 1'b1;
    else level_update = 1'b1;
    step();
    frame_start = 1'b0;
    level_update = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_engine_start"}, engine_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_seq_done"}, seq_done, 0);
    check({tag, "_pass_dir"}, pass_dir, 0);
    check({tag, "_pass_width"}, pass_width, 0);
    check({tag, "_pass_height"}, pass_height, 0);
    check({tag, "_pass_level"}, pass_level, 0);
    check({tag, "_levels_done"}, levels_done, 0);
  endtask

  // Called in the cycle right after a request is accepted; emulates the engine until seq_done.
  task automatic serve(input int lv, input int lat, input bit inj,
                       output int np, output int lvd, output int lw, output int lh);
    int exp_lv;
    int cyc;
    int cnt;
    bit fin;
    bit prev;
    exp_lv = build_model(lv);
    np = 0; lvd = -1; lw = -1; lh = -1; cnt = -1; fin = 0; prev = 0; cyc = 0;
    check("first_issue_start", engine_start, int'(model_q.size() > 0));
    check("first_issue_done", seq_done, int'(model_q.size() == 0));
    while (!fin && cyc < 4000) begin
      engine_done = 1'b0;
      level_update = 1'b0;
      if (inj && cyc == 1) begin level_update = 1'b1; level = 4'd3; end
      if (inj && cyc == 2) begin level_update = 1'b1; level = 4'd2; end
      if (prev) check("turnaround", int'(engine_start | seq_done), 1);
      prev = 0;
      if (engine_start) begin
        if (np < model_q.size()) begin
          check("pass_dir", pass_dir, model_q[np].dir);
          check("pass_width", pass_width, model_q[np].w);
          check("pass_height", pass_height, model_q[np].h);
          check("pass_level", pass_level, model_q[np].lvl);
        end else begin
          check("extra_pass", np, model_q.size());
        end
        check("busy_pass", busy, 1);
        lw = pass_width;
        lh = pass_height;
        np++;
        cnt = lat;
      end else if (seq_done) begin
        fin = 1;
        lvd = levels_done;
        check("busy_end", busy, 0);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          engine_done = 1'b1;
          prev = 1;
        end
      end
      if (!fin) step();
      cyc++;
    end
    engine_done = 1'b0;
    level_update = 1'b0;
    check("seq_finished", fin, 1);
    check("pass_count", np, model_q.size());
    check("levels_done_model", lvd, exp_lv);
    if (!inj) begin
      step();
      check("seq_done_once", seq_done, 0);
      check("no_restart", engine_start, 0);
      if (np > 0) check("pass_width_hold", pass_width, lw);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int np, lvd, lw, lh;
    vecs[0] = '{2,  1'b1, 5, 4,  2, 320, 240};
    vecs[1] = '{0,  1'b1, 3, 0,  0, -1,  -1};
    vecs[2] = '{10, 1'b0, 2, 16, 8, 5,   3};
    vecs[3] = '{15, 1'b1, 1, 16, 8, 5,   3};
    vecs[4] = '{1,  1'b0, 4, 2,  1, 640, 480};
    vecs[5] = '{7,  1'b1, 1, 14, 7, 10,  7};
    vecs[6] = '{0,  1'b0, 1, 0,  0, -1,  -1};

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Stray engine_done in IDLE.
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    check("stray_idle_start", engine_start, 0);
    check("stray_idle_busy", busy, 0);
    step();

    for (int i = 0; i < 7; i++) begin
      request(vecs[i].lv[3:0], vecs[i].fs);
      serve(vecs[i].lv, vecs[i].lat, 1'b0, np, lvd, lw, lh);
      check($sformatf("vec%0d_passes", i), np, vecs[i].exp_n);
      check($sformatf("vec%0d_levels", i), lvd, vecs[i].exp_lv);
      check($sformatf("vec%0d_last_w", i), lw, vecs[i].exp_w);
      check($sformatf("vec%0d_last_h", i), lh, vecs[i].exp_h);
      check($sformatf("vec%0d_levels_hold", i), levels_done, vecs[i].exp_lv);
    end

    // Stray engine_done while in DONE after a bypass.
    request(4'd0, 1'b1);
    check("bypass_seq_done", seq_done, 1);
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    check("stray_done_start", engine_start, 0);
    check("stray_done_busy", busy, 0);
    check("stray_done_seq", seq_done, 0);
    step();
    check("stray_done_idle", engine_start, 0);

    // Pending requests during a level-1 sequence; the newest (2) wins.
    request(4'd1, 1'b1);
    serve(1, 5, 1'b1, np, lvd, lw, lh);
    check("pend_first_levels", lvd, 1);
    step();
    check("pend_gap", engine_start, 0);
    step();
    serve(2, 5, 1'b0, np, lvd, lw, lh);
    check("pend_second_passes", np, 4);
    check("pend_second_levels", lvd, 2);

    // Reset in the WAIT of pass 3.
    request(4'd2, 1'b1);
    check("rst_p1_start", engine_start, 1);
    repeat (2) begin
      step();
      engine_done = 1'b1;
      step();
      engine_done = 1'b0;
      check("rst_next_start", engine_start, 1);
    end
    check("rst_p3_level", pass_level, 2);
    check("rst_p3_dir", pass_dir, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("midreset");
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    check("post_rst_start", engine_start, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_seq", seq_done, 0);
    step();
    request(4'd2, 1'b1);
    serve(2, 3, 1'b0, np, lvd, lw, lh);
    check("post_rst_levels", lvd, 2);

    // Randomized sequences against the model.
    for (int r = 0; r < 20; r++) begin
      int lv;
      int lat;
      bit fs;
      lv = $urandom_range(0, 15);
      lat = $urandom_range(1, 6);
      fs = 1'($urandom_range(0, 1));
      request(4'(lv), fs);
      serve(lv, lat, 1'b0, np, lvd, lw, lh);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dwt_pass_sequencer.md
# dwt_pass_sequencer

Sequences the separable DWT filter engine through the row and column passes for a multi-level decomposition. It takes the selected decomposition level and its update strobe from the level-select state machine, plus a per-frame start. It then issues one engine pass at a time, each with its direction and region dimensions. The region halves at every level, and the sequence ends early when the region becomes too small to filter.

## Interface
Parameters:
- IMAGE_WIDTH, 640: full-resolution region width in pixels.
- IMAGE_HEIGHT, 480: full-resolution region height in pixels.
- DIM_BITS, 10: width of the dimension outputs. Must hold IMAGE_WIDTH and IMAGE_HEIGHT.
- MAX_LEVEL, 4'd10: highest legal requested level. Larger requests are clamped to MAX_LEVEL.

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- level  in  4  requested decomposition level. 0 means bypass.
- level_update  in  1  one-cycle strobe indicating a new level.
- frame_start  in  1  one-cycle strobe requesting the decomposition for the current frame.
- engine_start  out  1  one-cycle pulse that launches one engine pass.
- engine_done  in  1  one-cycle pulse from the engine when the current pass is complete.
- pass_dir  out  1  0 = row pass, 1 = column pass. Valid while busy.
- pass_width  out  DIM_BITS  region width for the current pass.
- pass_height  out  DIM_BITS  region height for the current pass.
- pass_level  out  4  1-based level of the current pass.
- busy  out  1  high from the first engine_start through the final engine_done.
- seq_done  out  1  one-cycle pulse when a sequence finishes.
- levels_done  out  4  number of levels completed by the last sequence. Holds until the next seq_done.

## Operation
- States: IDLE, WAIT, DONE.
- Request definition: request = level_update | frame_start. The level is sampled in the cycle where the request is accepted, then clamped: target = min(level, MAX_LEVEL).
- IDLE, request with target = 0: go to DONE. No engine_start is issued and levels_done becomes 0.
- IDLE, request with target ≥ 1: issue pass 1.
  - engine_start is set to 1.
  - pass_dir = 0, pass_level = 1.
  - pass_width = IMAGE_WIDTH, pass_height = IMAGE_HEIGHT.
  - Go to WAIT.
- Dimensions at level k: width = IMAGE_WIDTH >> (k-1) and height = IMAGE_HEIGHT >> (k-1), both truncating.
- Order within a level: the row pass runs first, then the column pass, both with the same dimensions.
- WAIT, engine_done after a row pass: issue the column pass of the same level (pass_dir = 1, same dimensions).
- WAIT, engine_done after a column pass: increment levels_done internally.
  - If pass_level = target, go to DONE.
  - Otherwise compute level k+1. If its width < 2 or height < 2, go to DONE. This is a truncated sequence.
  - Otherwise issue the row pass of level k+1.
- DONE: pulse seq_done for one cycle. Publish levels_done. Go to IDLE.
- A request while the block is in WAIT or DONE sets a single pending flag and latches the newest level; later requests overwrite the latched level. Only one pending sequence is held.
- IDLE with the pending flag set: treat the pending flag as a request and clear it.
- engine_done is ignored outside WAIT.
- engine_start is never reissued before the matching engine_done.
- Reset, including reset in the middle of a sequence:
  - state becomes IDLE and the pending flag is cleared.
  - engine_start = 0, busy = 0, seq_done = 0.
  - pass_dir = 0, pass_width = 0, pass_height = 0, pass_level = 0, levels_done = 0.
  - Any engine pass in flight is abandoned. The engine is reset by the same reset.

## Timing
- All outputs are registered.
- Request accepted in IDLE at edge N: engine_start is high during cycle N+1, with pass_* valid in the same cycle. busy rises in cycle N+1.
- engine_done sampled at edge M: the next engine_start is high in cycle M+1 with updated pass_*. This gives one cycle of turnaround.
- After the final engine_done at edge M: seq_done is high in cycle M+1. busy falls in cycle M+1. levels_done updates in cycle M+1.
- Bypass request (target = 0) at edge N: seq_done is high in cycle N+1. busy stays 0.
- Pending request served: the new engine_start comes 2 cycles after seq_done (DONE → IDLE → issue).
- pass_* hold their values between engine_start pulses and after completion, until the next issue.

## Test plan
- Level 2, default parameters, engine responds 5 cycles after each start:
  - passes are (row,640,480,L1), (col,640,480,L1), (row,320,240,L2), (col,320,240,L2);
  - seq_done appears once, with levels_done = 2.
- Level 0 with frame_start: seq_done appears in the next cycle, no engine_start, levels_done = 0.
- Level 10:
  - 16 passes run, the last being (col,5,3,L8);
  - L9 height would be 1, so the sequence truncates;
  - levels_done = 8.
- During a level-1 sequence, send level_update with level 3, then with level 2:
  - the first sequence completes with levels_done = 1;
  - the next sequence starts 2 cycles after seq_done and runs with target 2.
- Stray engine_done in IDLE and in DONE: no state change, no engine_start.
- Reset during WAIT of pass 3:
  - all outputs return to their reset values in the next cycle;
  - a later engine_done is ignored;
  - a new frame_start begins again at pass 1.
